// File: rtl/iq_demod_pkg.sv
// Shared DSP definitions for the IQ demodulator: widths, FSM encoding, saturation helpers.
// Latency: none (declarations and pure functions only).
// Backpressure: not applicable.
package iq_demod_pkg;

    localparam int DW_DEF = 16;   // sample / LO / output width
    localparam int AW_DEF = 32;   // accumulator width
    localparam int LW_DEF = 12;   // window length width

    typedef enum logic {
        ST_IDLE  = 1'b0,          // no window open
        ST_ACCUM = 1'b1           // window open, counter = samples accepted so far
    } state_t;

    // Two's-complement clip to w bits: [-2^(w-1), 2^(w-1)-1].
    function automatic logic signed [63:0] sat(input logic signed [63:0] x, input int w);
        logic signed [63:0] mx;
        logic signed [63:0] mn;
        mx = (64'sd1 <<< (w - 1)) - 64'sd1;
        mn = -(64'sd1 <<< (w - 1));
        if (x > mx)
            return mx;
        else if (x < mn)
            return mn;
        else
            return x;
    endfunction

    // Symmetric clip to w bits: [-(2^(w-1)-1), 2^(w-1)-1]; most-negative code never produced.
    function automatic logic signed [63:0] sat_sym(input logic signed [63:0] x, input int w);
        logic signed [63:0] mx;
        mx = (64'sd1 <<< (w - 1)) - 64'sd1;
        if (x > mx)
            return mx;
        else if (x < -mx)
            return -mx;
        else
            return x;
    endfunction

endpackage

// File: rtl/iq_demod_sat_round.sv
// Round-half-up arithmetic right shift of an accumulator followed by symmetric saturation.
// Latency: combinational; the caller registers the result.
// Backpressure: none, evaluates every cycle.
module sat_round
    import iq_demod_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic signed [AW-1:0] acc,
    input  logic        [3:0]    shift,
    output logic signed [DW-1:0] y,
    output logic                 clip
);

    // One extra bit so adding the rounding bias can never wrap.
    logic signed [AW:0] ext;
    logic signed [AW:0] bias;
    logic signed [AW:0] sum;
    logic signed [AW:0] rsh;
    logic signed [63:0] wide;
    logic signed [63:0] clipped;

    // Bias is 2^(shift-1), which (1<<shift)>>1 yields, and is zero when shift is 0.
    always_comb begin
        ext     = {acc[AW-1], acc};
        bias    = ({{AW{1'b0}}, 1'b1} << shift) >> 1;
        sum     = ext + bias;
        rsh     = sum >>> shift;
        wide    = {{(63 - AW){rsh[AW]}}, rsh};
        clipped = sat_sym(wide, DW);
        y       = clipped[DW-1:0];
        clip    = (clipped != wide);
    end

endmodule

// File: rtl/iq_demod.sv
// Windowed IQ demodulator: multiplies adc by cos/sin, integrates over len samples, rounds/shifts/saturates.
// Latency: last sample of a window accepted in cycle t -> out_valid in cycle t+3.
// Backpressure: none; run=0 pauses the window, outputs are a one-cycle strobe that cannot be stalled.
module iq_demod
    import iq_demod_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF,
    parameter int LW = LW_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [DW-1:0] adc,
    input  logic signed [DW-1:0] cos,
    input  logic signed [DW-1:0] sin,
    input  logic                 run,
    input  logic        [LW-1:0] len,
    input  logic        [3:0]    shift,
    output logic signed [DW-1:0] i_out,
    output logic signed [DW-1:0] q_out,
    output logic                 out_valid,
    output logic                 out_sat
);

    // Window control
    state_t          state;
    logic [LW-1:0]   cnt;
    logic [LW-1:0]   len_r;
    logic [3:0]      shift_r;

    // Stage 1: products and window tags
    logic signed [2*DW-1:0] pi_r;
    logic signed [2*DW-1:0] pq_r;
    logic                   s1_vld;
    logic                   s1_first;
    logic                   s1_last;
    logic [3:0]             s1_shift;

    // Stage 2: accumulators; s2_vld marks a completed window sitting in acc_*
    logic signed [AW-1:0]   sc_i;
    logic signed [AW-1:0]   sc_q;
    logic signed [AW-1:0]   acc_i;
    logic signed [AW-1:0]   acc_q;
    logic                   s2_vld;
    logic [3:0]             s2_shift;

    // Stage 3 inputs
    logic signed [DW-1:0]   y_i;
    logic signed [DW-1:0]   y_q;
    logic                   clip_i;
    logic                   clip_q;

    // The shift travels with the window's samples so a new window that latches a
    // different shift cannot affect the result of the one still draining.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            len_r    <= '0;
            shift_r  <= '0;
            pi_r     <= '0;
            pq_r     <= '0;
            s1_vld   <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_shift <= '0;
        end else begin
            s1_vld   <= run;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            if (run) begin
                pi_r <= (2*DW)'(adc) * (2*DW)'(cos);
                pq_r <= (2*DW)'(adc) * (2*DW)'(sin);
                case (state)
                    ST_IDLE: begin
                        len_r    <= len;
                        shift_r  <= shift;
                        s1_shift <= shift;
                        s1_first <= 1'b1;
                        if (len < LW'(2)) begin
                            s1_last <= 1'b1;
                            cnt     <= '0;
                        end else begin
                            state <= ST_ACCUM;
                            cnt   <= LW'(1);
                        end
                    end
                    ST_ACCUM: begin
                        s1_shift <= shift_r;
                        if (cnt == len_r - LW'(1)) begin
                            s1_last <= 1'b1;
                            state   <= ST_IDLE;
                            cnt     <= '0;
                        end else begin
                            cnt <= cnt + LW'(1);
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

    // Q1.15 x Q1.15 -> keep bits [2DW-2:DW-2] (floor), sign-extended to the accumulator.
    assign sc_i = {{(AW-DW-1){pi_r[2*DW-2]}}, pi_r[2*DW-2:DW-2]};
    assign sc_q = {{(AW-DW-1){pq_r[2*DW-2]}}, pq_r[2*DW-2:DW-2]};

    // Product bits discarded by the scaling above.
    logic unused_prod_bits;
    assign unused_prod_bits = ^{pi_r[2*DW-1], pi_r[DW-3:0], pq_r[2*DW-1], pq_r[DW-3:0]};

    // Load on a window's first sample, accumulate otherwise, hold on idle cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_i    <= '0;
            acc_q    <= '0;
            s2_vld   <= 1'b0;
            s2_shift <= '0;
        end else begin
            s2_vld <= s1_vld & s1_last;
            if (s1_vld) begin
                acc_i <= s1_first ? sc_i : acc_i + sc_i;
                acc_q <= s1_first ? sc_q : acc_q + sc_q;
                if (s1_last)
                    s2_shift <= s1_shift;
            end
        end
    end

    sat_round #(.DW(DW), .AW(AW)) u_sat_round_i (
        .acc   (acc_i),
        .shift (s2_shift),
        .y     (y_i),
        .clip  (clip_i)
    );

    sat_round #(.DW(DW), .AW(AW)) u_sat_round_q (
        .acc   (acc_q),
        .shift (s2_shift),
        .y     (y_q),
        .clip  (clip_q)
    );

    // Register a finished window's results; they hold until the next strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            i_out     <= '0;
            q_out     <= '0;
            out_valid <= 1'b0;
            out_sat   <= 1'b0;
        end else begin
            out_valid <= s2_vld;
            if (s2_vld) begin
                i_out   <= y_i;
                q_out   <= y_q;
                out_sat <= clip_i | clip_q;
            end
        end
    end

endmodule

// File: tb/tb_iq_demod.sv
// Directed bench for iq_demod: table of single windows plus pause, back-to-back, reset and len-change sequences.
// Latency: checks the t+3 strobe timing against the cycle each last sample was presented.
// Backpressure: not applicable; every wait is a fixed drain of cycles.
module tb_iq_demod;

    localparam int DW = 16;
    localparam int AW = 32;
    localparam int LW = 12;

    logic                 clk = 1'b0;
    logic                 rst;
    logic signed [DW-1:0] adc_s;
    logic signed [DW-1:0] cos_s;
    logic signed [DW-1:0] sin_s;
    logic                 run;
    logic        [LW-1:0] len_s;
    logic        [3:0]    shift_s;
    logic signed [DW-1:0] i_out;
    logic signed [DW-1:0] q_out;
    logic                 out_valid;
    logic                 out_sat;

    iq_demod #(.DW(DW), .AW(AW), .LW(LW)) dut (
        .clk       (clk),
        .rst       (rst),
        .adc       (adc_s),
        .cos       (cos_s),
        .sin       (sin_s),
        .run       (run),
        .len       (len_s),
        .shift     (shift_s),
        .i_out     (i_out),
        .q_out     (q_out),
        .out_valid (out_valid),
        .out_sat   (out_sat)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    // Cycle index: during the cycle before edge E, cyc == E-1.
    always @(posedge clk) cyc = cyc + 1;

    // Strobe log, sampled mid-cycle.
    int q_cyc[$];
    int q_i[$];
    int q_q[$];
    int q_sat[$];
    always @(negedge clk) begin
        if (out_valid) begin
            q_cyc.push_back(cyc);
            q_i.push_back(int'(i_out));
            q_q.push_back(int'(q_out));
            q_sat.push_back(int'(out_sat));
        end
    end

    typedef struct {
        string name;
        int    adc;
        int    cs;
        int    sn;
        int    len;
        int    sh;
        int    nsamp;
        int    ei;
        int    eq;
        int    es;
    } vec_t;

    vec_t vecs[8];

    function automatic vec_t mk(string n, int a, int c, int s, int l, int sh, int ns,
                                int ei, int eq, int es);
        vec_t v;
        v.name = n; v.adc = a; v.cs = c; v.sn = s; v.len = l; v.sh = sh;
        v.nsamp = ns; v.ei = ei; v.eq = eq; v.es = es;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        q_cyc.delete(); q_i.delete(); q_q.delete(); q_sat.delete();
    endtask

    task automatic set_in(input int a, input int c, input int s, input int l, input int sh);
        adc_s   = 16'(a);
        cos_s   = 16'(c);
        sin_s   = 16'(s);
        len_s   = LW'(l);
        shift_s = 4'(sh);
    endtask

    // Present n samples with optional run-low gap before sample index pause_at.
    task automatic do_window(input int a, input int c, input int s, input int l, input int sh,
                             input int n, input int pause_at, input int pause_len,
                             output int t_last);
        t_last = -1;
        set_in(a, c, s, l, sh);
        for (int k = 0; k < n; k++) begin
            if (k == pause_at) begin
                for (int p = 0; p < pause_len; p++) begin
                    run = 1'b0;
                    step();
                end
            end
            run    = 1'b1;
            t_last = cyc;
            step();
        end
        run = 1'b0;
    endtask

    // Drain, then expect exactly one strobe at t_last+3 with the given values, held afterwards.
    task automatic check_window(input string name, input int t_last,
                                input int ei, input int eq, input int es);
        for (int k = 0; k < 6; k++) step();
        chk({name, "_strobes"}, q_cyc.size(), 1);
        if (q_cyc.size() >= 1) begin
            chk({name, "_latency"}, q_cyc[0] - t_last, 3);
            chk({name, "_i"}, q_i[0], ei);
            chk({name, "_q"}, q_q[0], eq);
            chk({name, "_sat"}, q_sat[0], es);
        end
        chk({name, "_i_hold"}, int'(i_out), ei);
        clear_log();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin : main
        int t_last;
        int t4;
        int t8;
        int t0;
        int bad_gap;
        int bad_val;

        vecs[0] = mk("basic",     16384, 32767,      0, 4, 2, 4,  32767,      0, 0);
        vecs[1] = mk("sat_pos",   32767, 32767,      0, 4, 0, 4,  32767,      0, 1);
        vecs[2] = mk("sat_neg",  -32767, 32767,      0, 4, 0, 4, -32767,      0, 1);
        vecs[3] = mk("floor",      1000,  2000,  -3000, 1, 0, 1,    122,   -184, 0);
        vecs[4] = mk("len3_sh1",   8192, 16384, -16384, 3, 1, 3,  12288, -12288, 0);
        vecs[5] = mk("round",         3, 16384, -16384, 1, 1, 1,      2,     -1, 0);
        vecs[6] = mk("len0",      16384, 16384,      0, 0, 0, 1,  16384,      0, 0);
        vecs[7] = mk("sat_q",     32767,     0, -32767, 2, 0, 2,      0, -32767, 1);

        rst = 1'b1;
        run = 1'b0;
        set_in(0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) step();
        chk("reset_i", int'(i_out), 0);
        chk("reset_q", int'(q_out), 0);
        chk("reset_valid", int'(out_valid), 0);
        chk("reset_sat", int'(out_sat), 0);
        rst = 1'b0;
        step();
        clear_log();

        for (int v = 0; v < 8; v++) begin
            do_window(vecs[v].adc, vecs[v].cs, vecs[v].sn, vecs[v].len, vecs[v].sh,
                      vecs[v].nsamp, -1, 0, t_last);
            check_window(vecs[v].name, t_last, vecs[v].ei, vecs[v].eq, vecs[v].es);
        end

        // Run low for 3 cycles after sample 2.
        do_window(16384, 32767, 0, 4, 2, 4, 2, 3, t_last);
        check_window("pause", t_last, 32767, 0, 0);

        // Back-to-back len=2 windows over 20 continuous samples.
        set_in(16384, 32767, 0, 2, 2);
        t0 = cyc;
        run = 1'b1;
        for (int k = 0; k < 20; k++) step();
        run = 1'b0;
        for (int k = 0; k < 6; k++) step();
        chk("b2b_strobes", q_cyc.size(), 10);
        bad_gap = 0;
        bad_val = 0;
        for (int k = 0; k < q_cyc.size(); k++) begin
            if (k > 0 && q_cyc[k] - q_cyc[k-1] != 2) bad_gap = bad_gap + 1;
            if (q_i[k] != 16384 || q_q[k] != 0 || q_sat[k] != 0) bad_val = bad_val + 1;
        end
        chk("b2b_gaps", bad_gap, 0);
        chk("b2b_values", bad_val, 0);
        if (q_cyc.size() >= 1)
            chk("b2b_first_latency", q_cyc[0] - t0, 4);
        clear_log();

        // Reset mid-window: partial window discarded, next window clean.
        do_window(16384, 32767, 0, 4, 2, 2, -1, 0, t_last);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_i", int'(i_out), 0);
        chk("rst_mid_valid", int'(out_valid), 0);
        for (int k = 0; k < 6; k++) step();
        chk("rst_mid_strobes", q_cyc.size(), 0);
        clear_log();
        do_window(16384, 32767, 0, 4, 2, 4, -1, 0, t_last);
        check_window("after_rst", t_last, 32767, 0, 0);

        // len/shift change mid-window only affects the next window.
        t4 = -1;
        t8 = -1;
        set_in(16384, 32767, 0, 4, 2);
        for (int k = 0; k < 12; k++) begin
            if (k == 2) set_in(16384, 32767, 0, 8, 3);
            if (k == 4) set_in(4096, 32767, 0, 8, 3);
            run = 1'b1;
            if (k == 3)  t4 = cyc;
            if (k == 11) t8 = cyc;
            step();
        end
        run = 1'b0;
        for (int k = 0; k < 6; k++) step();
        chk("lenchg_strobes", q_cyc.size(), 2);
        if (q_cyc.size() >= 2) begin
            chk("lenchg_w1_latency", q_cyc[0] - t4, 3);
            chk("lenchg_w1_i", q_i[0], 32767);
            chk("lenchg_w2_latency", q_cyc[1] - t8, 3);
            chk("lenchg_w2_i", q_i[1], 8191);
            chk("lenchg_w2_q", q_q[1], 0);
        end
        clear_log();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
